qr_arbiter: RTL
===============

QR_ARBITER -- requirements
Module: qr_arbiter

Interface
REQ-001 SHALL have parameter TBITS, default 64, output stream data width; TBITS of 52 or more is required.
REQ-002 SHALL have parameter CAL_TIMEOUT, default 255, the maximum number of idle cycles between engine results.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have ports req0_data_dout input 52, req0_empty_n input 1, req0_read output 1 (requester 0 FIFO read side).
REQ-006 SHALL have ports req1_data_dout input 52, req1_empty_n input 1, req1_read output 1 (requester 1 FIFO read side).
REQ-007 SHALL have ports eng_valid output 1 and eng_in output 52, the QR_CORDIC input beat.
REQ-008 SHALL have ports eng_out_valid input 1 and eng_out input 52, the QR_CORDIC result beat.
REQ-009 SHALL have ports osif_data_din output TBITS, osif_last_din output 1, osif_user_din output 1 (requester id), osif_full_n input 1 and osif_write output 1.
REQ-010 SHALL have port err_timeout, output, 1 bit, a one-cycle abort pulse.

Function
REQ-011 SHALL implement FSM states IDLE, READ, CAL and WB.
REQ-012 SHALL make the transitions: IDLE->READ on grant; READ->CAL on 8th accepted beat; CAL->WB on 8th stored result; CAL->IDLE on timeout; WB->IDLE on 8th written beat.
REQ-013 SHALL grant in IDLE when any empty_n is high: a single request wins; when both request, the requester not served last wins; grant is registered (READ starts next cycle).
REQ-014 SHALL drive selected reqN_read = 1 throughout READ; the other reqN_read = 0; accepted beat = read & empty_n.
REQ-015 SHALL assert eng_valid only on accepted beats, with eng_in = selected reqN_data_dout combinationally; eng_in = 0 otherwise.
REQ-016 SHALL count beats 0..7 on accepted beats only; gaps (empty_n low) stall the count.
REQ-017 SHALL, in CAL, write eng_out into an 8x52 result buffer at index = result count on each eng_out_valid.
REQ-018 SHALL ignore eng_out_valid outside CAL.
REQ-019 SHALL, in CAL, clear the timeout counter on each eng_out_valid and otherwise increment it.
REQ-020 SHALL, when the timeout counter reaches CAL_TIMEOUT, pulse err_timeout for 1 cycle, discard the buffer, go to IDLE and advance the RR pointer.
REQ-021 SHALL, in WB, set osif_write = osif_full_n and osif_data_din = zero-extended buffer[wr_idx]; wr_idx advances only when written.
REQ-022 SHALL set osif_last_din = 1 on the beat with wr_idx = 7 and osif_user_din = granted id throughout WB; outside WB, osif_data_din, osif_last_din and osif_user_din = 0.
REQ-023 SHALL update the RR pointer to the served id on WB->IDLE.
REQ-024 SHALL give a completed job the minimum latency of 1 (grant) + 8 (read) + 8 (results) + 8 (write) cycles.
REQ-025 SHALL let a new request arriving during READ/CAL/WB wait; no preemption.

Reset
REQ-026 SHALL, on rst, set state = IDLE, all counters = 0 and the RR pointer to favour req0, and clear the buffer valid.
REQ-027 SHALL hold all outputs at 0 during and after reset until a grant.
REQ-028 SHALL, on rst asserted mid-job, abort the job with no osif_write, no err_timeout and no partial burst.

Structure
REQ-029 SHALL place DATA_LENGTH=13, NUM_COL=8, the 52-bit beat width and the FSM state encoding in shared package qr_pkg.
REQ-030 SHALL implement the 8x52 result buffer as sub-module qr_result_buf (write port: idx, data, we; read port: idx, data).

Verification
REQ-031 SHALL cover: req0 only, 8 contiguous beats 0x1..0x8, engine returns 0xA1..0xA8 -> 8 osif writes 0xA1..0xA8, user=0, last on 8th.
REQ-032 SHALL cover: req0 and req1 both pending from reset -> req0 served first, then req1; a third job with both pending -> req0.
REQ-033 SHALL cover: req1 empty_n low for 3 cycles after beat 4 -> eng_valid gaps of 3, exactly 8 eng_valid pulses total.
REQ-034 SHALL cover: osif_full_n low for 5 cycles at wr_idx=2 -> osif_write low, data held, no beat lost or duplicated.
REQ-035 SHALL cover: engine stops after 5 results, CAL_TIMEOUT=16 -> err_timeout pulse 16 cycles after 5th result, no osif_write, next grant to other requester.
REQ-036 SHALL cover: rst asserted at read beat 4 -> next cycle all outputs 0, state IDLE, fresh job then completes correctly.

Source files
------------

// File: rtl/qr_pkg.sv
// rtl/qr_pkg.sv - shared constants and FSM encoding for the QR arbiter
package qr_pkg;

  localparam int DATA_LENGTH = 13;
  localparam int NUM_COL     = 8;
  localparam int BEAT_W      = DATA_LENGTH * 4;
  localparam int IDX_W       = $clog2(NUM_COL);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_CAL  = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [IDX_W-1:0]  idx_t;

endpackage

// File: rtl/qr_result_buf.sv
// rtl/qr_result_buf.sv - 8-entry result buffer, one write port, one async read port
import qr_pkg::*;

module qr_result_buf (
  input  logic  clk,
  input  logic  we,
  input  idx_t  wr_idx,
  input  beat_t wr_data,
  input  idx_t  rd_idx,
  output beat_t rd_data
);

  beat_t mem_q [NUM_COL];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/qr_arbiter.sv
// rtl/qr_arbiter.sv - two-requester round-robin front end for a shared QR_CORDIC engine
import qr_pkg::*;

module qr_arbiter #(
  parameter int TBITS       = 64,
  parameter int CAL_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [51:0]      req0_data_dout,
  input  logic             req0_empty_n,
  output logic             req0_read,
  input  logic [51:0]      req1_data_dout,
  input  logic             req1_empty_n,
  output logic             req1_read,
  output logic             eng_valid,
  output logic [51:0]      eng_in,
  input  logic             eng_out_valid,
  input  logic [51:0]      eng_out,
  output logic [TBITS-1:0] osif_data_din,
  output logic             osif_last_din,
  output logic             osif_user_din,
  input  logic             osif_full_n,
  output logic             osif_write,
  output logic             err_timeout
);

  localparam int TMO_W = $clog2(CAL_TIMEOUT + 1);

  logic [1:0]       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  idx_t             beat_q, beat_d;
  idx_t             res_q, res_d;
  idx_t             wr_q, wr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             buf_valid_q, buf_valid_d;

  logic  sel_en;
  beat_t sel_data;
  logic  buf_we;
  beat_t buf_rd;

  qr_result_buf u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_idx  (res_q),
    .wr_data (eng_out),
    .rd_idx  (wr_q),
    .rd_data (buf_rd)
  );

  assign sel_en   = gnt_q ? req1_empty_n   : req0_empty_n;
  assign sel_data = gnt_q ? req1_data_dout : req0_data_dout;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    beat_d        = beat_q;
    res_d         = res_q;
    wr_d          = wr_q;
    tmo_d         = tmo_q;
    err_d         = 1'b0;
    buf_valid_d   = buf_valid_q;
    buf_we        = 1'b0;
    req0_read     = 1'b0;
    req1_read     = 1'b0;
    eng_valid     = 1'b0;
    eng_in        = '0;
    osif_write    = 1'b0;
    osif_data_din = '0;
    osif_last_din = 1'b0;
    osif_user_din = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // last_q holds the id served last, so the other one wins a tie
        if (req0_empty_n || req1_empty_n) begin
          state_d = ST_READ;
          gnt_d   = (req0_empty_n && req1_empty_n) ? ~last_q : req1_empty_n;
          beat_d  = '0;
        end
      end
      ST_READ: begin
        req0_read = ~gnt_q;
        req1_read = gnt_q;
        if (sel_en) begin
          eng_valid = 1'b1;
          eng_in    = sel_data;
          beat_d    = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_d = ST_CAL;
            res_d   = '0;
            tmo_d   = '0;
          end
        end
      end
      ST_CAL: begin
        if (eng_out_valid) begin
          buf_we = 1'b1;
          res_d  = res_q + 3'd1;
          tmo_d  = '0;
          if (res_q == 3'd7) begin
            state_d     = ST_WB;
            wr_d        = '0;
            buf_valid_d = 1'b1;
          end
        end else if (tmo_q == TMO_W'(CAL_TIMEOUT - 1)) begin
          err_d       = 1'b1;
          state_d     = ST_IDLE;
          last_d      = gnt_q;
          res_d       = '0;
          tmo_d       = '0;
          buf_valid_d = 1'b0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        osif_write    = osif_full_n & buf_valid_q;
        osif_data_din = TBITS'(buf_rd);
        osif_last_din = (wr_q == 3'd7);
        osif_user_din = gnt_q;
        if (osif_write) begin
          wr_d = wr_q + 3'd1;
          if (wr_q == 3'd7) begin
            state_d     = ST_IDLE;
            last_d      = gnt_q;
            buf_valid_d = 1'b0;
          end
        end
      end
    endcase

    // reset kills any in-flight beat on the same cycle
    if (rst) begin
      buf_we        = 1'b0;
      req0_read     = 1'b0;
      req1_read     = 1'b0;
      eng_valid     = 1'b0;
      eng_in        = '0;
      osif_write    = 1'b0;
      osif_data_din = '0;
      osif_last_din = 1'b0;
      osif_user_din = 1'b0;
    end
  end

  assign err_timeout = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      beat_q      <= '0;
      res_q       <= '0;
      wr_q        <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      beat_q      <= beat_d;
      res_q       <= res_d;
      wr_q        <= wr_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      buf_valid_q <= buf_valid_d;
    end
  end

endmodule
